// File: rtl/dbus_pkg.sv
// Shared encodings for the data-bus master: core access sizes, bus SIZE codes and FSM states.
package dbus_pkg;

  // Core-side size, taken from funct3[1:0]; 2'b11 is handled as a word
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [1:0] BUS_WORD = 2'b00;
  localparam logic [1:0] BUS_HALF = 2'b01;
  localparam logic [1:0] BUS_BYTE = 2'b10;

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] BUS  = 2'b01;
  localparam logic [1:0] RESP = 2'b10;

  function automatic logic [1:0] bus_size(input logic [1:0] sz);
    case (sz)
      SZ_BYTE: bus_size = BUS_BYTE;
      SZ_HALF: bus_size = BUS_HALF;
      default: bus_size = BUS_WORD;
    endcase
  endfunction

  function automatic logic is_aligned(input logic [1:0] sz, input logic [1:0] addr_lo);
    case (sz)
      SZ_BYTE: is_aligned = 1'b1;
      SZ_HALF: is_aligned = ~addr_lo[0];
      default: is_aligned = (addr_lo == 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/dbus_master_if.sv
// Core-side request/response handshake between the MEM stage and dbus_master.
interface dbus_master_if #(
  parameter int BIT_WIDTH = 32
);
  logic                 req_i;
  logic                 we_i;
  logic [1:0]           size_i;
  logic                 uns_i;
  logic [BIT_WIDTH-1:0] addr_i;
  logic [BIT_WIDTH-1:0] wdata_i;
  logic [BIT_WIDTH-1:0] rdata_o;
  logic                 done_o;
  logic                 busy_o;
  logic                 err_o;
  logic                 tmo_o;

  modport master (
    output req_i, we_i, size_i, uns_i, addr_i, wdata_i,
    input  rdata_o, done_o, busy_o, err_o, tmo_o
  );

  modport slave (
    input  req_i, we_i, size_i, uns_i, addr_i, wdata_i,
    output rdata_o, done_o, busy_o, err_o, tmo_o
  );
endinterface

// File: rtl/dbus_load_fmt.sv
// Right-aligned bus data to 32-bit register value, sign- or zero-extended by access size.
module dbus_load_fmt
  import dbus_pkg::*;
#(
  parameter int BIT_WIDTH = 32
) (
  input  logic [BIT_WIDTH-1:0] ddt,
  input  logic [1:0]           size,
  input  logic                 uns,
  output logic [BIT_WIDTH-1:0] data
);

  always_comb begin
    data = ddt;
    case (size)
      SZ_BYTE: data = {{(BIT_WIDTH-8){ddt[7] & ~uns}}, ddt[7:0]};
      SZ_HALF: data = {{(BIT_WIDTH-16){ddt[15] & ~uns}}, ddt[15:0]};
      default: data = ddt;
    endcase
  end

endmodule

// File: rtl/dbus_master.sv
// Data-bus initiator: turns one MEM-stage load/store into a DAD/MREQ/WRITE/SIZE/DDT cycle
// and returns formatted load data once ACKD_n is seen.
module dbus_master
  import dbus_pkg::*;
#(
  parameter int BIT_WIDTH = 32,
  parameter int TIMEOUT   = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  dbus_master_if.slave         core,
  output logic [BIT_WIDTH-1:0] DAD,
  output logic                 MREQ,
  output logic                 WRITE,
  output logic [1:0]           SIZE,
  inout  wire  [BIT_WIDTH-1:0] DDT,
  input  logic                 ACKD_n
);

  localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT);

  logic [1:0]           state;
  logic [7:0]           cnt;
  logic [BIT_WIDTH-1:0] wdata_q;
  logic [1:0]           size_q;
  logic                 uns_q;
  logic [BIT_WIDTH-1:0] fmt_data;

  function automatic logic [BIT_WIDTH-1:0] place(input logic [1:0] sz,
                                                 input logic [BIT_WIDTH-1:0] d);
    case (sz)
      SZ_BYTE: place = {{(BIT_WIDTH-8){1'b0}}, d[7:0]};
      SZ_HALF: place = {{(BIT_WIDTH-16){1'b0}}, d[15:0]};
      default: place = d;
    endcase
  endfunction

  // Store data is only on the pins while a write cycle is actually requested
  assign DDT = (MREQ && WRITE) ? wdata_q : {BIT_WIDTH{1'bz}};

  dbus_load_fmt #(.BIT_WIDTH(BIT_WIDTH)) u_fmt (
    .ddt  (DDT),
    .size (size_q),
    .uns  (uns_q),
    .data (fmt_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      cnt          <= 8'd0;
      MREQ         <= 1'b0;
      WRITE        <= 1'b0;
      SIZE         <= BUS_WORD;
      DAD          <= '0;
      wdata_q      <= '0;
      size_q       <= SZ_WORD;
      uns_q        <= 1'b0;
      core.rdata_o <= '0;
      core.done_o  <= 1'b0;
      core.busy_o  <= 1'b0;
      core.err_o   <= 1'b0;
      core.tmo_o   <= 1'b0;
    end else begin
      core.done_o <= 1'b0;
      core.err_o  <= 1'b0;
      core.tmo_o  <= 1'b0;
      case (state)
        IDLE: begin
          if (core.req_i) begin
            if (is_aligned(core.size_i, core.addr_i[1:0])) begin
              state       <= BUS;
              cnt         <= 8'd0;
              MREQ        <= 1'b1;
              WRITE       <= core.we_i;
              DAD         <= core.addr_i;
              SIZE        <= bus_size(core.size_i);
              wdata_q     <= place(core.size_i, core.wdata_i);
              size_q      <= core.size_i;
              uns_q       <= core.uns_i;
              core.busy_o <= 1'b1;
            end else begin
              core.err_o <= 1'b1;
            end
          end
        end
        BUS: begin
          cnt <= cnt + 8'd1;
          // An acknowledge on the timeout edge still completes the access
          if (!ACKD_n) begin
            if (!WRITE) core.rdata_o <= fmt_data;
            MREQ        <= 1'b0;
            WRITE       <= 1'b0;
            core.busy_o <= 1'b0;
            state       <= RESP;
          end else if (cnt + 8'd1 == TMO_LIMIT) begin
            MREQ        <= 1'b0;
            WRITE       <= 1'b0;
            core.busy_o <= 1'b0;
            core.tmo_o  <= 1'b1;
            state       <= IDLE;
          end
        end
        RESP: begin
          core.done_o <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dbus_master.sv
// Bench for dbus_master: table of load/store vectors against a byte-addressed big-endian
// memory model, plus hand sequences for timeout and reset during a bus cycle.
module tb_dbus_master;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] DAD;
  logic        MREQ, WRITE;
  logic [1:0]  SIZE;
  wire  [31:0] DDT;
  logic        ACKD_n = 1'b1;

  logic        mem_drv = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  assign DDT = mem_drv ? mem_rdata : 'z;

  dbus_master_if #(.BIT_WIDTH(32)) core ();

  dbus_master #(.BIT_WIDTH(32), .TIMEOUT(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .core   (core),
    .DAD    (DAD),
    .MREQ   (MREQ),
    .WRITE  (WRITE),
    .SIZE   (SIZE),
    .DDT    (DDT),
    .ACKD_n (ACKD_n)
  );

  always #5 clk = ~clk;

  logic [7:0]  mem [logic [31:0]];
  int          lat = 1;
  int          mcnt = 0;
  logic [31:0] last_wr = 32'h0;
  logic [31:0] last_load = 32'h0;
  int          n_tests = 0;
  int          n_fail = 0;
  logic [31:0] exp_q [$];

  function automatic logic [7:0] rb(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 8'h00;
  endfunction

  // Bus data is right-aligned; unused upper lanes carry junk the master must ignore
  function automatic logic [31:0] rd_bus(input logic [31:0] a, input logic [1:0] s);
    case (s)
      2'b10:   return {24'hA5A5A5, rb(a)};
      2'b01:   return {16'hA5A5, rb(a), rb(a + 1)};
      default: return {rb(a), rb(a + 1), rb(a + 2), rb(a + 3)};
    endcase
  endfunction

  task automatic wr_bus(input logic [31:0] a, input logic [1:0] s, input logic [31:0] d);
    last_wr = d;
    case (s)
      2'b10: mem[a] = d[7:0];
      2'b01: begin mem[a] = d[15:8]; mem[a + 1] = d[7:0]; end
      default: begin
        mem[a] = d[31:24]; mem[a + 1] = d[23:16]; mem[a + 2] = d[15:8]; mem[a + 3] = d[7:0];
      end
    endcase
    if (a == 32'hF000_0000) $display("[TB] stdout: %c", d[7:0]);
  endtask

  // Memory responder: acknowledges lat cycles after MREQ rises
  always @(negedge clk) begin
    if (MREQ) begin
      mcnt++;
      if (!WRITE) begin
        mem_drv   = 1'b1;
        mem_rdata = rd_bus(DAD, SIZE);
      end
      if (mcnt >= lat && ACKD_n) begin
        ACKD_n = 1'b0;
        if (WRITE) wr_bus(DAD, SIZE, DDT);
      end
    end else begin
      mcnt    = 0;
      ACKD_n  = 1'b1;
      mem_drv = 1'b0;
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // A released net reads Z on 4-state simulators and 0 on 2-state ones
  function automatic logic ddt_released();
    return (DDT === 32'hzzzz_zzzz) || (DDT === 32'h0);
  endfunction

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic        err;
    logic [1:0]  bsize;
    logic [31:0] exp;   // load: rdata_o, store: data on DDT
  } vec_t;

  task automatic drive(input vec_t v);
    lat          = v.lat;
    core.req_i   = 1'b1;
    core.we_i    = v.we;
    core.size_i  = v.size;
    core.uns_i   = v.uns;
    core.addr_i  = v.addr;
    core.wdata_i = v.wdata;
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int          n;
    bit          seen_drop;
    logic [31:0] got, e;
    drive(v);
    if (!v.err) exp_q.push_back(v.exp);
    @(posedge clk); #1;
    if (v.err) begin
      check({nm, "_err"}, 32'(core.err_o), 32'd1);
      check({nm, "_err_mreq"}, 32'(MREQ), 32'd0);
      check({nm, "_err_busy"}, 32'(core.busy_o), 32'd0);
      core.req_i = 1'b0;
      @(posedge clk); #1;
      check({nm, "_err_pulse"}, 32'(core.err_o), 32'd0);
      check({nm, "_err_mreq2"}, 32'(MREQ), 32'd0);
      return;
    end
    check({nm, "_mreq"}, 32'(MREQ), 32'd1);
    check({nm, "_write"}, 32'(WRITE), 32'(v.we));
    check({nm, "_size"}, 32'(SIZE), 32'(v.bsize));
    check({nm, "_dad"}, DAD, v.addr);
    check({nm, "_busy"}, 32'(core.busy_o), 32'd1);
    if (v.we) check({nm, "_ddt"}, DDT, v.exp);
    n = 0;
    seen_drop = 1'b0;
    while (n < 40) begin
      @(posedge clk); #1;
      n++;
      if (v.we && !MREQ && !seen_drop) begin
        seen_drop = 1'b1;
        check({nm, "_ddt_rel"}, 32'(ddt_released()), 32'd1);
      end
      if (core.done_o || core.tmo_o) break;
    end
    check({nm, "_done"}, 32'(core.done_o), 32'd1);
    check({nm, "_lat"}, 32'(n), 32'(v.lat + 1));
    core.req_i = 1'b0;
    got = v.we ? last_wr : core.rdata_o;
    e = exp_q.pop_front();
    check({nm, "_data"}, got, e);
    if (v.we) check({nm, "_rdata_hold"}, core.rdata_o, last_load);
    else      last_load = v.exp;
    @(posedge clk); #1;
    check({nm, "_done_pulse"}, 32'(core.done_o), 32'd0);
    check({nm, "_mreq_gap"}, 32'(MREQ), 32'd0);
  endtask

  vec_t tbl [16];
  vec_t v;
  int   n;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    mem[32'h100] = 8'h12; mem[32'h101] = 8'h34; mem[32'h102] = 8'h56; mem[32'h103] = 8'h78;
    mem[32'h203] = 8'h80; mem[32'h204] = 8'hBE; mem[32'h205] = 8'hEF;

    //          we    size   uns   addr           wdata          lat err   bsize  exp
    tbl[0]  = '{1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0,         1, 1'b0, 2'b00, 32'h1234_5678};
    tbl[1]  = '{1'b0, 2'b00, 1'b0, 32'h0000_0203, 32'h0,         1, 1'b0, 2'b10, 32'hFFFF_FF80};
    tbl[2]  = '{1'b0, 2'b00, 1'b1, 32'h0000_0203, 32'h0,         2, 1'b0, 2'b10, 32'h0000_0080};
    tbl[3]  = '{1'b0, 2'b01, 1'b1, 32'h0000_0204, 32'h0,         1, 1'b0, 2'b01, 32'h0000_BEEF};
    tbl[4]  = '{1'b0, 2'b01, 1'b0, 32'h0000_0204, 32'h0,         1, 1'b0, 2'b01, 32'hFFFF_BEEF};
    tbl[5]  = '{1'b1, 2'b00, 1'b0, 32'hF000_0000, 32'hFFFF_FF41, 1, 1'b0, 2'b10, 32'h0000_0041};
    tbl[6]  = '{1'b1, 2'b10, 1'b0, 32'hFF00_0000, 32'h0,         2, 1'b0, 2'b00, 32'h0};
    tbl[7]  = '{1'b0, 2'b01, 1'b0, 32'h0000_1001, 32'h0,         1, 1'b1, 2'b00, 32'h0};
    tbl[8]  = '{1'b0, 2'b10, 1'b0, 32'h0000_0102, 32'h0,         1, 1'b1, 2'b00, 32'h0};
    tbl[9]  = '{1'b1, 2'b01, 1'b0, 32'h0000_0210, 32'h1234_ABCD, 2, 1'b0, 2'b01, 32'h0000_ABCD};
    tbl[10] = '{1'b0, 2'b01, 1'b0, 32'h0000_0210, 32'h0,         3, 1'b0, 2'b01, 32'hFFFF_ABCD};
    tbl[11] = '{1'b0, 2'b11, 1'b0, 32'h0000_0100, 32'h0,         4, 1'b0, 2'b00, 32'h1234_5678};
    tbl[12] = '{1'b0, 2'b00, 1'b0, 32'h0000_0101, 32'h0,         1, 1'b0, 2'b10, 32'h0000_0034};
    tbl[13] = '{1'b1, 2'b10, 1'b0, 32'h0000_0300, 32'hDEAD_BEEF, 1, 1'b0, 2'b00, 32'hDEAD_BEEF};
    tbl[14] = '{1'b0, 2'b10, 1'b1, 32'h0000_0300, 32'h0,         1, 1'b0, 2'b00, 32'hDEAD_BEEF};
    tbl[15] = '{1'b0, 2'b00, 1'b1, 32'h0000_0000, 32'h0,         1, 1'b1, 2'b00, 32'h0};
    tbl[15].addr = 32'h0000_0301;  // odd byte address: aligned, not an error
    tbl[15].err  = 1'b0;
    tbl[15].bsize = 2'b10;
    tbl[15].exp  = 32'h0000_00AD;

    core.req_i = 1'b0; core.we_i = 1'b0; core.size_i = 2'b00; core.uns_i = 1'b0;
    core.addr_i = 32'h0; core.wdata_i = 32'h0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_mreq", 32'(MREQ), 32'd0);
    check("rst_write", 32'(WRITE), 32'd0);
    check("rst_size", 32'(SIZE), 32'd0);
    check("rst_dad", DAD, 32'h0);
    check("rst_rdata", core.rdata_o, 32'h0);
    check("rst_flags", {28'h0, core.done_o, core.busy_o, core.err_o, core.tmo_o}, 32'h0);
    check("rst_ddt", 32'(ddt_released()), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 16; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // Timeout: memory never acknowledges
    v = tbl[0];
    v.lat = 1000;
    drive(v);
    @(posedge clk); #1;
    n = 0;
    while (n < 20) begin
      @(posedge clk); #1;
      n++;
      if (core.tmo_o || core.done_o) break;
    end
    check("tmo_pulse", 32'(core.tmo_o), 32'd1);
    check("tmo_cycles", 32'(n), 32'd4);
    check("tmo_mreq", 32'(MREQ), 32'd0);
    check("tmo_busy", 32'(core.busy_o), 32'd0);
    check("tmo_done", 32'(core.done_o), 32'd0);
    core.req_i = 1'b0;
    @(posedge clk); #1;
    check("tmo_one_cycle", 32'(core.tmo_o), 32'd0);
    run_vec(tbl[0], "after_tmo");

    // Reset while a latency-3 store is on the bus
    v = tbl[13];
    v.addr = 32'h0000_0400; v.wdata = 32'h1122_3344; v.exp = 32'h1122_3344; v.lat = 3;
    drive(v);
    @(posedge clk); #1;
    check("rstbus_mreq_pre", 32'(MREQ), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("rstbus_mreq", 32'(MREQ), 32'd0);
    check("rstbus_busy", 32'(core.busy_o), 32'd0);
    check("rstbus_ddt", 32'(ddt_released()), 32'd1);
    core.req_i = 1'b0;
    n = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (core.done_o) n++;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    if (core.done_o) n++;
    check("rstbus_no_done", 32'(n), 32'd0);
    check("rstbus_no_write", {rb(32'h400), rb(32'h401), rb(32'h402), rb(32'h403)}, 32'h0);
    v.wdata = 32'hCAFE_F00D; v.exp = 32'hCAFE_F00D; v.lat = 1;
    last_load = 32'h0;
    run_vec(v, "post_rst_store");
    check("post_rst_mem", {rb(32'h400), rb(32'h401), rb(32'h402), rb(32'h403)}, 32'hCAFE_F00D);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dbus_master.md
Name: dbus_master

Overview:
- CPU-side initiator for the data-memory bus. It converts single load/store requests from the core's MEM stage into DAD/MREQ/WRITE/SIZE/DDT bus cycles.
- It waits for ACKD_n, then returns load data formatted to 32 bits with sign or zero extension.
- Sits between the MEM stage and the top-level data-bus pins. While a request is outstanding, busy_o stalls the pipeline.

Parameters:
- BIT_WIDTH, 32, data/address width
- TIMEOUT, 255, maximum cycles in BUS before the access is abandoned (8-bit counter)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low
- req_i  in  1  core requests an access; held until done_o, err_o or tmo_o
- we_i  in  1  1=store, 0=load
- size_i  in  2  00 byte, 01 half, 10 word (funct3[1:0]); 11 is treated as word
- uns_i  in  1  load zero-extends (funct3[2])
- addr_i  in  32  byte address
- wdata_i  in  32  store data, right-aligned
- rdata_o  out  32  formatted load data; valid while done_o=1 after a load, holds its value until the next load completes
- done_o  out  1  one-cycle pulse: access completed
- busy_o  out  1  high while in BUS state
- err_o  out  1  one-cycle pulse: misaligned request rejected
- tmo_o  out  1  one-cycle pulse: access timed out
- DAD  out  32  bus address
- MREQ  out  1  bus request
- WRITE  out  1  1=write cycle
- SIZE  out  2  00 word, 01 half, 10 byte
- DDT  inout  32  bus data; driven only when MREQ&WRITE, otherwise high-Z
- ACKD_n  in  1  active-low acknowledge from memory

Behaviour:
- Reset (rst=0, asynchronous):
  - State=IDLE.
  - MREQ=0, WRITE=0, SIZE=00, DAD=0.
  - DDT released to Z.
  - rdata_o=0; done_o, err_o, tmo_o, busy_o = 0; timeout counter = 0.
  - Reset during BUS abandons the access immediately; no done_o is produced.
- States: IDLE, BUS, RESP. All bus outputs and status outputs are registered.
- IDLE:
  - Enter BUS when req_i=1 and the access is aligned. Aligned means: word needs addr_i[1:0]=00; half needs addr_i[0]=0; byte is always aligned.
  - On entering BUS, latch:
    - DAD=addr_i; WRITE=we_i; MREQ=1.
    - SIZE = byte→10, half→01, word→00.
    - Store data placement: word→wdata_i; half→{16'b0,wdata_i[15:0]}; byte→{24'b0,wdata_i[7:0]}.
  - Misaligned request: err_o pulses for one cycle, no bus cycle is issued, state stays IDLE.
- BUS:
  - busy_o=1. The counter increments every cycle.
  - At a rising edge with ACKD_n=0:
    - On a load, capture and format DDT into rdata_o.
    - Clear MREQ and WRITE, release DDT, go to RESP.
  - At a rising edge where the counter reaches TIMEOUT with ACKD_n still 1: clear MREQ, pulse tmo_o, go to IDLE.
  - If ACKD_n=0 on the same edge the counter reaches TIMEOUT, the acknowledge wins.
- RESP: done_o=1 for exactly one cycle, then IDLE.
- req_i is not sampled in BUS or RESP. MREQ is therefore low for at least one cycle between consecutive accesses.
- Load formatting (bus data is right-aligned, big-endian byte order within a word):
  - word: rdata_o=DDT.
  - half: rdata_o=DDT[15:0], extended by DDT[15] unless uns_i.
  - byte: rdata_o=DDT[7:0], extended by DDT[7] unless uns_i.
  - uns_i is latched at accept time.
- Latency:
  - With 1-cycle memory: request accepted at edge 0, MREQ high after edge 0, ACKD_n sampled low at edge 1, done_o high between edge 2 and edge 3.
  - Each additional memory wait cycle adds one cycle.
- No address decode: 0xF0000000 (stdout) and 0xFF000000 (exit) pass through as ordinary stores.

Decomposition:
- Package dbus_pkg:
  - size encodings: core SZ_BYTE/SZ_HALF/SZ_WORD and bus BUS_WORD=00/BUS_HALF=01/BUS_BYTE=10
  - state encodings: IDLE/BUS/RESP
- One combinational sub-module, dbus_load_fmt: inputs DDT, size, uns; output 32-bit extended data. It is reused by any future instruction-side narrow fetch.

Test Plan:
- Word load at 0x100, memory bytes 12 34 56 78, latency 1 → MREQ=1 WRITE=0 SIZE=00 DAD=0x100; done_o two edges after accept; rdata_o=0x12345678.
- Signed byte load at 0x203, byte 0x80 → rdata_o=0xFFFFFF80; same access with uns_i=1 → 0x00000080; half load 0xBEEF with uns_i=1 → 0x0000BEEF.
- Byte store to 0xF0000000 of wdata_i=0x41 → SIZE=10, WRITE=1, DDT=0x00000041 while MREQ=1; DDT=Z the cycle after ack; bench prints 'A'.
- Half load at 0x1001 → err_o pulses once, MREQ stays 0, busy_o stays 0.
- ACKD_n held high, TIMEOUT=4 → tmo_o pulses after 4 BUS cycles, MREQ drops, next request is accepted normally.
- Memory latency 3, with rst pulsed low mid-BUS → MREQ=0 and DDT=Z immediately; no done_o; a fresh word store after reset completes and writes memory correctly.
